// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - preset-loaded countdown timer with run/pause control
//
// Purpose: loads a phase-dependent preset and counts it down on i_tick,
// pausing while i_hold is high, pulsing o_done at expiry and o_err when
// an illegal load (phase G with i_specific=1) is rejected.
//
// Ports:
//   i_clk       clock, rising-edge active
//   i_rst_n     asynchronous active-low reset
//   i_load      load request for the preset selected by i_state/i_specific
//   i_state     phase code: E=00, A=01, G=10, L=11
//   i_specific  alternate preset for A; makes a G load illegal
//   i_tick      single-cycle count enable
//   i_hold      freezes counting while high
//   o_count     remaining time (registered)
//   o_busy      high in RUN or PAUSE (registered)
//   o_done      one-cycle expiry pulse (registered)
//   o_err       one-cycle rejected-load pulse (registered)
module phase_timer #(
  parameter int WIDTH  = 6,
  parameter int P_E    = 30,
  parameter int P_A    = 15,
  parameter int P_A_SP = 22,
  parameter int P_G    = 30,
  parameter int P_L    = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [1:0]       i_state,
  input  logic             i_specific,
  input  logic             i_tick,
  input  logic             i_hold,
  output logic [WIDTH-1:0] o_count,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err
);

  localparam int MAXV = (1 << WIDTH) - 1;

  // Presets are clamped to [1, 2^WIDTH-1] so a loaded countdown always
  // takes at least one tick and never truncates to a wrong value.
  function automatic logic [WIDTH-1:0] sat(input int p);
    if (p > MAXV) return WIDTH'(MAXV);
    else if (p <= 0) return WIDTH'(1);
    else return WIDTH'(p);
  endfunction

  localparam logic [WIDTH-1:0] L_E    = sat(P_E);
  localparam logic [WIDTH-1:0] L_A    = sat(P_A);
  localparam logic [WIDTH-1:0] L_A_SP = sat(P_A_SP);
  localparam logic [WIDTH-1:0] L_G    = sat(P_G);
  localparam logic [WIDTH-1:0] L_L    = sat(P_L);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_t;

  state_t           r_fsm;
  logic [WIDTH-1:0] r_count;
  logic             r_busy;
  logic             r_done;
  logic             r_err;

  logic [WIDTH-1:0] w_preset;
  logic             w_reject;

  always_comb begin
    w_preset = L_E;
    case (i_state)
      2'b00:   w_preset = L_E;
      2'b01:   w_preset = i_specific ? L_A_SP : L_A;
      2'b10:   w_preset = L_G;
      default: w_preset = L_L;
    endcase
  end

  assign w_reject = (i_state == 2'b10) && i_specific;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fsm   <= S_IDLE;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      // A load cycle (accepted or rejected) consumes tick and hold.
      if (i_load) begin
        if (w_reject) begin
          r_err <= 1'b1;
        end else begin
          r_count <= w_preset;
          r_busy  <= 1'b1;
          r_fsm   <= i_hold ? S_PAUSE : S_RUN;
        end
      end else begin
        case (r_fsm)
          S_RUN: begin
            if (i_hold) begin
              r_fsm <= S_PAUSE;
            end else if (i_tick) begin
              if (r_count <= WIDTH'(1)) begin
                r_count <= '0;
                r_fsm   <= S_IDLE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_count <= r_count - WIDTH'(1);
              end
            end
          end
          S_PAUSE: begin
            // Release cycle only resumes RUN; its tick is dropped.
            if (!i_hold) r_fsm <= S_RUN;
          end
          default: begin
            r_fsm   <= S_IDLE;
            r_count <= '0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_count = r_count;
  assign o_busy  = r_busy;
  assign o_done  = r_done;
  assign o_err   = r_err;

endmodule

// File: tb/tb_phase_timer.sv
// tb/tb_phase_timer.sv - directed vector bench for phase_timer
module tb_phase_timer;

  logic       clk;
  logic       rst_n;
  logic       load;
  logic [1:0] st;
  logic       sp;
  logic       tick;
  logic       hold;
  logic [5:0] count;
  logic       busy;
  logic       done;
  logic       err;

  logic       rst4_n;
  logic       load4;
  logic       tick4;
  logic [3:0] count4;
  logic       busy4;
  logic       done4;
  logic       err4;

  int n_cmp  = 0;
  int n_fail = 0;

  phase_timer u_dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_load     (load),
    .i_state    (st),
    .i_specific (sp),
    .i_tick     (tick),
    .i_hold     (hold),
    .o_count    (count),
    .o_busy     (busy),
    .o_done     (done),
    .o_err      (err)
  );

  phase_timer #(.WIDTH(4), .P_E(30)) u_dut4 (
    .i_clk      (clk),
    .i_rst_n    (rst4_n),
    .i_load     (load4),
    .i_state    (2'b00),
    .i_specific (1'b0),
    .i_tick     (tick4),
    .i_hold     (1'b0),
    .o_count    (count4),
    .o_busy     (busy4),
    .o_done     (done4),
    .o_err      (err4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       ld;
    logic [1:0] st;
    logic       sp;
    logic       tk;
    logic       hd;
    int         cnt;
    logic       bsy;
    logic       dn;
    logic       er;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic ld, logic [1:0] s, logic p, logic tk, logic hd,
                              int cnt, logic bsy, logic dn, logic er);
    vec_t v;
    v.ld = ld; v.st = s; v.sp = p; v.tk = tk; v.hd = hd;
    v.cnt = cnt; v.bsy = bsy; v.dn = dn; v.er = er;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int c, input int b, input int d, input int e);
    chk({tag, ".count"}, int'(count), c);
    chk({tag, ".busy"},  int'(busy),  b);
    chk({tag, ".done"},  int'(done),  d);
    chk({tag, ".err"},   int'(err),   e);
  endtask

  task automatic drive(input logic l, input logic [1:0] s, input logic p,
                       input logic t, input logic h);
    load = l; st = s; sp = p; tick = t; hold = h;
  endtask

  initial begin
    drive(0, 2'b00, 0, 0, 0);
    load4 = 0; tick4 = 0;
    rst_n = 0; rst4_n = 0;

    // idle behaviour and rejected load in IDLE
    vecs.push_back(mk(0, 2'b00, 0, 1, 0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 2'b00, 0, 1, 1,  0, 0, 0, 0));
    vecs.push_back(mk(1, 2'b10, 1, 0, 0,  0, 0, 0, 1));
    vecs.push_back(mk(0, 2'b00, 0, 0, 0,  0, 0, 0, 0));
    // L countdown to expiry
    vecs.push_back(mk(1, 2'b11, 0, 0, 0,  5, 1, 0, 0));
    vecs.push_back(mk(0, 2'b00, 0, 1, 0,  4, 1, 0, 0));
    vecs.push_back(mk(0, 2'b00, 0, 1, 0,  3, 1, 0, 0));
    vecs.push_back(mk(0, 2'b00, 0, 1, 0,  2, 1, 0, 0));
    vecs.push_back(mk(0, 2'b00, 0, 1, 0,  1, 1, 0, 0));
    vecs.push_back(mk(0, 2'b00, 0, 1, 0,  0, 0, 1, 0));
    vecs.push_back(mk(0, 2'b00, 0, 1, 0,  0, 0, 0, 0));
    // preset selection, reloads while running
    vecs.push_back(mk(1, 2'b01, 1, 0, 0, 22, 1, 0, 0));
    vecs.push_back(mk(1, 2'b01, 0, 0, 0, 15, 1, 0, 0));
    vecs.push_back(mk(1, 2'b10, 0, 0, 0, 30, 1, 0, 0));
    vecs.push_back(mk(1, 2'b00, 1, 0, 0, 30, 1, 0, 0));
    vecs.push_back(mk(1, 2'b11, 1, 0, 0,  5, 1, 0, 0));
    // count to 10 then illegal load with a tick: no change, err pulse
    vecs.push_back(mk(1, 2'b01, 0, 0, 0, 15, 1, 0, 0));
    vecs.push_back(mk(0, 2'b00, 0, 1, 0, 14, 1, 0, 0));
    vecs.push_back(mk(0, 2'b00, 0, 1, 0, 13, 1, 0, 0));
    vecs.push_back(mk(0, 2'b00, 0, 1, 0, 12, 1, 0, 0));
    vecs.push_back(mk(0, 2'b00, 0, 1, 0, 11, 1, 0, 0));
    vecs.push_back(mk(0, 2'b00, 0, 1, 0, 10, 1, 0, 0));
    vecs.push_back(mk(1, 2'b10, 1, 1, 0, 10, 1, 0, 1));
    vecs.push_back(mk(0, 2'b00, 0, 0, 0, 10, 1, 0, 0));
    // hold for 4 ticks, release-cycle tick dropped
    vecs.push_back(mk(1, 2'b00, 0, 0, 0, 30, 1, 0, 0));
    vecs.push_back(mk(0, 2'b00, 0, 1, 0, 29, 1, 0, 0));
    vecs.push_back(mk(0, 2'b00, 0, 1, 1, 29, 1, 0, 0));
    vecs.push_back(mk(0, 2'b00, 0, 1, 1, 29, 1, 0, 0));
    vecs.push_back(mk(0, 2'b00, 0, 1, 1, 29, 1, 0, 0));
    vecs.push_back(mk(0, 2'b00, 0, 1, 1, 29, 1, 0, 0));
    vecs.push_back(mk(0, 2'b00, 0, 1, 0, 29, 1, 0, 0));
    vecs.push_back(mk(0, 2'b00, 0, 1, 0, 28, 1, 0, 0));
    // load with hold lands in PAUSE
    vecs.push_back(mk(1, 2'b11, 0, 0, 1,  5, 1, 0, 0));
    vecs.push_back(mk(0, 2'b00, 0, 1, 1,  5, 1, 0, 0));
    vecs.push_back(mk(0, 2'b00, 0, 1, 0,  5, 1, 0, 0));
    vecs.push_back(mk(0, 2'b00, 0, 1, 0,  4, 1, 0, 0));
    vecs.push_back(mk(0, 2'b00, 0, 1, 0,  3, 1, 0, 0));
    // load beats tick at count 3
    vecs.push_back(mk(1, 2'b00, 0, 1, 0, 30, 1, 0, 0));
    vecs.push_back(mk(0, 2'b00, 0, 1, 0, 29, 1, 0, 0));

    #13;
    chk_all("reset", 0, 0, 0, 0);
    chk("reset4.count", int'(count4), 0);
    chk("reset4.busy",  int'(busy4),  0);

    @(negedge clk);
    rst_n = 1; rst4_n = 1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].ld, vecs[i].st, vecs[i].sp, vecs[i].tk, vecs[i].hd);
      @(posedge clk);
      #1;
      chk_all($sformatf("v%0d", i), vecs[i].cnt, int'(vecs[i].bsy),
              int'(vecs[i].dn), int'(vecs[i].er));
    end

    // asynchronous reset mid-countdown, inputs ignored while low
    @(negedge clk);
    drive(1, 2'b11, 0, 1, 0);
    #2;
    rst_n = 0;
    #1;
    chk_all("arst", 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk_all("arst_held", 0, 0, 0, 0);
    @(negedge clk);
    drive(0, 2'b00, 0, 1, 0);
    #2;
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk_all($sformatf("post_rst%0d", i), 0, 0, 0, 0);
    end
    @(negedge clk);
    drive(1, 2'b00, 0, 0, 0);
    @(posedge clk);
    #1;
    chk_all("post_rst_load", 30, 1, 0, 0);

    // WIDTH=4: saturated preset, reset at 7 with no done
    @(negedge clk);
    drive(0, 2'b00, 0, 0, 0);
    load4 = 1;
    @(posedge clk);
    #1;
    chk("w4_load.count", int'(count4), 15);
    chk("w4_load.busy",  int'(busy4),  1);
    @(negedge clk);
    load4 = 0; tick4 = 1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("w4_tick%0d.done", i), int'(done4), 0);
    end
    chk("w4_at7.count", int'(count4), 7);
    @(negedge clk);
    #2;
    rst4_n = 0;
    #1;
    chk("w4_arst.count", int'(count4), 0);
    chk("w4_arst.busy",  int'(busy4),  0);
    @(negedge clk);
    rst4_n = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("w4_post%0d.done", i),  int'(done4),  0);
      chk($sformatf("w4_post%0d.count", i), int'(count4), 0);
      chk($sformatf("w4_post%0d.err", i),   int'(err4),   0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/phase_timer.md
PHASE_TIMER -- requirements
Module: phase_timer

Interface
REQ-001 Parameter WIDTH, default 6: counter width in bits.
REQ-002 Parameter P_E, default 30: preset for state E (00).
REQ-003 Parameter P_A, default 15: preset for state A (01) with specific=0.
REQ-004 Parameter P_A_SP, default 22: preset for state A (01) with specific=1.
REQ-005 Parameter P_G, default 30: preset for state G (10) with specific=0.
REQ-006 Parameter P_L, default 5: preset for state L (11).
REQ-007 Clocking SHALL be as follows: one clock; reset is asynchronous and active-low.
REQ-008 clk  input  1  clock, all state updates on rising edge.
REQ-009 rst_n  input  1  asynchronous active-low reset.
REQ-010 load  input  1  request to load the preset selected by state/specific.
REQ-011 state  input  2  phase code: E=00, A=01, G=10, L=11.
REQ-012 specific  input  1  selects the alternate preset for A; makes G illegal.
REQ-013 tick  input  1  single-cycle count enable (time base).
REQ-014 hold  input  1  freezes counting while high.
REQ-015 count  output  WIDTH  current remaining time.
REQ-016 busy  output  1  high while a countdown is active (RUN or PAUSE).
REQ-017 done  output  1  one-cycle pulse at expiry.
REQ-018 err  output  1  one-cycle pulse when a load is rejected.

Function
REQ-019 The FSM SHALL have states IDLE, RUN and PAUSE; busy SHALL be 1 exactly in RUN and PAUSE.
REQ-020 Preset select SHALL be: E->P_E; A,sp=0->P_A; A,sp=1->P_A_SP; G,sp=0->P_G; L->P_L, with specific ignored for E and L.
REQ-021 A preset exceeding 2^WIDTH-1 SHALL saturate to 2^WIDTH-1; a preset of 0 SHALL be loaded as 1.
REQ-022 A load with state=G and specific=1 SHALL be rejected: count and FSM unchanged, err=1 on the next cycle.
REQ-023 An accepted load in any FSM state SHALL set count=preset and enter RUN (or PAUSE if hold=1) on the next rising edge (1-cycle latency).
REQ-024 load SHALL take priority over tick and hold in the same cycle; no decrement occurs in a load cycle.
REQ-025 In RUN with tick=1 and hold=0, count SHALL decrement by 1 per tick.
REQ-026 In RUN, tick=1 with count==1 SHALL set count=0, enter IDLE and assert done=1, all on the next edge.
REQ-027 done SHALL be high for exactly one cycle per expiry and SHALL never coincide with err.
REQ-028 hold=1 in RUN SHALL move to PAUSE with count frozen; hold=0 in PAUSE SHALL return to RUN, with a tick in the release cycle ignored.
REQ-029 In IDLE, tick and hold SHALL have no effect; count SHALL remain 0.
REQ-030 count SHALL never wrap below 0 or above its loaded value.
REQ-031 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-032 rst_n=0 SHALL immediately force IDLE, count=0, busy=0, done=0 and err=0, independent of clk.
REQ-033 Reset asserted mid-countdown SHALL abort without a done pulse; after release the block SHALL wait in IDLE for a load.
REQ-034 Inputs SHALL be ignored while rst_n=0; the first accepted edge is the first rising clk edge after rst_n deasserts.

Verification
REQ-035 Default params, load with state=L -> count=5 and busy=1 next cycle; after 5 ticks count=0, done pulses once, busy=0.
REQ-036 load with state=A, specific=1 -> count=22; load with state=A, specific=0 -> count=15.
REQ-037 load with state=G, specific=1 while counting at 10 -> err pulses once, count stays 10, busy stays 1.
REQ-038 Countdown from 30 with hold=1 for 4 ticks -> count frozen, busy=1; after hold release, ticking resumes from the same value and the release-cycle tick is ignored.
REQ-039 load and tick in the same cycle at count=3 with state=E -> count=30, no decrement, no done.
REQ-040 WIDTH=4 with P_E=30, load E -> count=15 (saturated); rst_n pulsed low at count=7 -> count=0, busy=0, no done.
